// File: rtl/ddr_arb_pkg.sv
// Shared types for the DDR Avalon-MM arbiter.
//   arb_state_t : arbiter FSM states
//   tag_t       : read-return tag {requester id, burst length}
//   rr_next     : next round-robin index, wrapping to 0 after n-1
package ddr_arb_pkg;

  // Sized for the largest supported configuration (8 requesters, 8-bit burstcount).
  localparam int unsigned TAG_ID_W    = 3;
  localparam int unsigned TAG_BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WBURST
  } arb_state_t;

  typedef struct packed {
    logic [TAG_ID_W-1:0]    id;
    logic [TAG_BURST_W-1:0] burst;
  } tag_t;

  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// Synchronous FIFO holding read-return tags in command order.
//   clk, reset : clock, synchronous active-high reset (clears occupancy)
//   push, din  : write side; a push is accepted when not full, or when full
//                and a pop happens in the same cycle
//   pop, dout  : read side; dout shows the head entry (valid when !empty)
//   full, empty, count : occupancy status
module ddr_arb_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ddr_avl_arbiter.sv
// Round-robin arbiter sharing one DDR controller Avalon-MM local port between
// NREQ masters. Write bursts lock the grant; read responses are steered back
// in order using a tag FIFO.
//   clk_clk, reset_reset      : clock, synchronous active-high reset
//   req_*                     : per-requester Avalon-MM slave side (flat slices)
//   amm_*                     : master side towards the memory controller
//   amm_ready                 : controller calibration done; gates arbitration
// Optional macro DDR_ARB_PERF_CNT_EN adds saturating perf_grant_cnt (32 bits per
// requester) and perf_stall_cnt outputs.
module ddr_avl_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BURST_W   = 3,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [NREQ*ADDR_W-1:0]   req_address,
  input  logic [NREQ*BURST_W-1:0]  req_burstcount,
  input  logic [NREQ-1:0]          req_read,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*DATA_W-1:0]   req_writedata,
  input  logic [NREQ*DATA_W/8-1:0] req_byteenable,
  output logic [NREQ-1:0]          req_waitrequest,
  output logic [DATA_W-1:0]        req_readdata,
  output logic [NREQ-1:0]          req_readdatavalid,
  output logic [ADDR_W-1:0]        amm_address,
  output logic [BURST_W-1:0]       amm_burstcount,
  output logic                     amm_read,
  output logic                     amm_write,
  output logic [DATA_W-1:0]        amm_writedata,
  output logic [DATA_W/8-1:0]      amm_byteenable,
  input  logic                     amm_waitrequest,
  input  logic [DATA_W-1:0]        amm_readdata,
  input  logic                     amm_readdatavalid,
  input  logic                     amm_ready
`ifdef DDR_ARB_PERF_CNT_EN
  ,
  output logic [NREQ*32-1:0]       perf_grant_cnt,
  output logic [31:0]              perf_stall_cnt
`endif
);

  localparam int unsigned GW = $clog2(NREQ);

  arb_state_t          state;
  logic [GW-1:0]       gnt;
  logic [GW-1:0]       rr_ptr;
  logic [BURST_W-1:0]  wbeats;

  logic [NREQ-1:0]     req_any;
  logic [GW-1:0]       pick;
  logic                pick_valid;

  logic [ADDR_W-1:0]   sel_addr;
  logic [BURST_W-1:0]  sel_burst;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_be;
  logic                sel_rd;
  logic                sel_wr;

  tag_t                push_tag;
  tag_t                head;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [$clog2(TAG_DEPTH):0] fifo_count;

  logic [BURST_W-1:0]  rd_left;
  logic [BURST_W-1:0]  rd_cur;
  logic                rd_beat;
  logic                err_q;

  assign req_any = req_read | req_write;

  // First active requester at or after rr_ptr, cyclically.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!pick_valid && req_any[(32'(rr_ptr) + k) % NREQ]) begin
        pick       = GW'((32'(rr_ptr) + k) % NREQ);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr  = req_address[32'(gnt)*ADDR_W +: ADDR_W];
    sel_burst = req_burstcount[32'(gnt)*BURST_W +: BURST_W];
    sel_wdata = req_writedata[32'(gnt)*DATA_W +: DATA_W];
    sel_be    = req_byteenable[32'(gnt)*(DATA_W/8) +: DATA_W/8];
    sel_rd    = req_read[gnt];
    sel_wr    = req_write[gnt];
  end

  // Granted requester drives the controller; reads are held off while every
  // tag slot is occupied so read data can always be routed.
  always_comb begin
    amm_address     = '0;
    amm_burstcount  = '0;
    amm_read        = 1'b0;
    amm_write       = 1'b0;
    amm_writedata   = '0;
    amm_byteenable  = '0;
    req_waitrequest = '1;
    if (state != IDLE) begin
      amm_address    = sel_addr;
      amm_burstcount = sel_burst;
      amm_writedata  = sel_wdata;
      amm_byteenable = sel_be;
      if (state == GRANT) begin
        amm_read  = sel_rd && !fifo_full;
        amm_write = sel_wr && !sel_rd;
      end else begin
        amm_write = sel_wr;
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt == GW'(i)) begin
          req_waitrequest[i] = amm_waitrequest || (state == GRANT && sel_rd && fifo_full);
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
      wbeats <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (amm_ready && pick_valid) begin
            gnt   <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (amm_read && !amm_waitrequest) begin
            state  <= IDLE;
            rr_ptr <= GW'(rr_next(32'(gnt), NREQ));
          end else if (amm_write && !amm_waitrequest) begin
            if (sel_burst == BURST_W'(1)) begin
              state  <= IDLE;
              rr_ptr <= GW'(rr_next(32'(gnt), NREQ));
            end else begin
              wbeats <= sel_burst - BURST_W'(1);
              state  <= WBURST;
            end
          end
        end
        WBURST: begin
          if (amm_write && !amm_waitrequest) begin
            if (wbeats == BURST_W'(1)) begin
              state  <= IDLE;
              rr_ptr <= GW'(rr_next(32'(gnt), NREQ));
            end else begin
              wbeats <= wbeats - BURST_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_push = (state == GRANT) && amm_read && !amm_waitrequest;
  assign push_tag  = '{id: TAG_ID_W'(gnt), burst: TAG_BURST_W'(sel_burst)};

  ddr_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH ($bits(tag_t))
  ) u_tag_fifo (
    .clk   (clk_clk),
    .reset (reset_reset),
    .push  (fifo_push),
    .din   (push_tag),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // rd_left==0 means the head burst has not started; load its length on the
  // first beat and pop on the last one.
  always_comb begin
    rd_beat           = amm_readdatavalid && !fifo_empty;
    rd_cur            = (rd_left == '0) ? BURST_W'(head.burst) : rd_left;
    fifo_pop          = rd_beat && (rd_cur == BURST_W'(1));
    req_readdata      = amm_readdata;
    req_readdatavalid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_readdatavalid[i] = rd_beat && (32'(head.id) == i);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rd_left <= '0;
      err_q   <= 1'b0;
    end else begin
      if (rd_beat) rd_left <= fifo_pop ? '0 : rd_cur - BURST_W'(1);
      if (amm_readdatavalid && fifo_empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset) begin
      assert (!err_q);
      assert (!(state == WBURST && sel_rd));
      assert (32'(fifo_count) <= TAG_DEPTH);
      assert (fifo_empty || (32'(head.id) < NREQ && head.burst != '0 &&
                             (32'(head.burst) >> BURST_W) == 0));
    end
  end

`ifdef DDR_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt [NREQ];
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int unsigned i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (state == IDLE && amm_ready && pick_valid && pick == GW'(i) && grant_cnt[i] != '1)
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
      if (amm_waitrequest && (amm_read || amm_write) && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_comb begin
    perf_grant_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) perf_grant_cnt[i*32 +: 32] = grant_cnt[i];
    perf_stall_cnt = stall_cnt;
  end
`endif

endmodule

// File: tb/tb_ddr_avl_arbiter.sv
module tb_ddr_avl_arbiter;

  localparam int unsigned NREQ      = 3;
  localparam int unsigned ADDR_W    = 25;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned BURST_W   = 3;
  localparam int unsigned TAG_DEPTH = 8;

  logic                     clk_clk = 1'b0;
  logic                     reset_reset;
  logic [NREQ*ADDR_W-1:0]   req_address;
  logic [NREQ*BURST_W-1:0]  req_burstcount;
  logic [NREQ-1:0]          req_read;
  logic [NREQ-1:0]          req_write;
  logic [NREQ*DATA_W-1:0]   req_writedata;
  logic [NREQ*DATA_W/8-1:0] req_byteenable;
  logic [NREQ-1:0]          req_waitrequest;
  logic [DATA_W-1:0]        req_readdata;
  logic [NREQ-1:0]          req_readdatavalid;
  logic [ADDR_W-1:0]        amm_address;
  logic [BURST_W-1:0]       amm_burstcount;
  logic                     amm_read;
  logic                     amm_write;
  logic [DATA_W-1:0]        amm_writedata;
  logic [DATA_W/8-1:0]      amm_byteenable;
  logic                     amm_waitrequest;
  logic [DATA_W-1:0]        amm_readdata;
  logic                     amm_readdatavalid;
  logic                     amm_ready;
`ifdef DDR_ARB_PERF_CNT_EN
  logic [NREQ*32-1:0]       perf_grant_cnt;
  logic [31:0]              perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_clk = ~clk_clk;

  ddr_avl_arbiter #(
    .NREQ      (NREQ),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_W   (BURST_W),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset       (reset_reset),
    .req_address       (req_address),
    .req_burstcount    (req_burstcount),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_writedata     (req_writedata),
    .req_byteenable    (req_byteenable),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .amm_address       (amm_address),
    .amm_burstcount    (amm_burstcount),
    .amm_read          (amm_read),
    .amm_write         (amm_write),
    .amm_writedata     (amm_writedata),
    .amm_byteenable    (amm_byteenable),
    .amm_waitrequest   (amm_waitrequest),
    .amm_readdata      (amm_readdata),
    .amm_readdatavalid (amm_readdatavalid),
    .amm_ready         (amm_ready)
`ifdef DDR_ARB_PERF_CNT_EN
    ,
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 2 time units after a rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk_clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] b);
    req_read[i]                          = rd;
    req_write[i]                         = wr;
    req_address[i*ADDR_W +: ADDR_W]      = a;
    req_burstcount[i*BURST_W +: BURST_W] = b;
  endtask

  task automatic do_reset();
    reset_reset       = 1'b1;
    req_read          = '0;
    req_write         = '0;
    amm_waitrequest   = 1'b0;
    amm_readdatavalid = 1'b0;
    step();
    reset_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  e;
    logic [63:0] wbase;
    int          b;
    int          nacc;
    int          wpat [7];
    int          vpat [9];

    reset_reset       = 1'b1;
    req_address       = '0;
    req_burstcount    = '0;
    req_read          = '0;
    req_write         = '0;
    req_writedata     = '0;
    req_byteenable    = '1;
    amm_waitrequest   = 1'b0;
    amm_readdata      = '0;
    amm_readdatavalid = 1'b0;
    amm_ready         = 1'b0;
    step();
    step();
    #1;
    chk("rst_waitreq", 64'(req_waitrequest), 64'h7);
    chk("rst_rdvalid", 64'(req_readdatavalid), 64'h0);
    chk("rst_read", 64'(amm_read), 64'h0);
    chk("rst_write", 64'(amm_write), 64'h0);
    chk("rst_addr", 64'(amm_address), 64'h0);
    chk("rst_burst", 64'(amm_burstcount), 64'h0);
    chk("rst_wdata", 64'(amm_writedata), 64'h0);
    chk("rst_be", 64'(amm_byteenable), 64'h0);
    reset_reset = 1'b0;

    // Calibration gate
    set_req(0, 1'b1, 1'b0, 25'h100, 3'd1);
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("cal_no_read", 64'(amm_read), 64'h0);
      chk("cal_waitreq0", 64'(req_waitrequest[0]), 64'h1);
      step();
    end
    amm_ready = 1'b1;
    #1;
    chk("cal_arb_cycle", 64'(amm_read), 64'h0);
    step();
    #1;
    chk("cal_read", 64'(amm_read), 64'h1);
    chk("cal_addr", 64'(amm_address), 64'h100);
    chk("cal_burst", 64'(amm_burstcount), 64'h1);
    chk("cal_waitreq", 64'(req_waitrequest), 64'h6);
    step();
    set_req(0, 1'b0, 1'b0, 25'h100, 3'd1);
    amm_readdatavalid = 1'b1;
    amm_readdata      = 64'h1111_2222_3333_4444;
    #1;
    chk("cal_rdv", 64'(req_readdatavalid), 64'h1);
    chk("cal_rdata", req_readdata, 64'h1111_2222_3333_4444);
    chk("cal_idle", 64'(amm_read), 64'h0);
    step();
    amm_readdatavalid = 1'b0;
    #1;
    chk("cal_rdv_done", 64'(req_readdatavalid), 64'h0);

    // Round robin with all three requesters reading
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 25'(32'h10 + i), 3'd1);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_idle", 64'(amm_read), 64'h0);
      step();
      #1;
      e = 3'b111;
      e[k % 3] = 1'b0;
      chk("rr_read", 64'(amm_read), 64'h1);
      chk("rr_addr", 64'(amm_address), 64'(32'h10 + (k % 3)));
      chk("rr_waitreq", 64'(req_waitrequest), 64'(e));
      step();
    end
    req_read = '0;

    // Write burst lock: req1 burst of 4 while req0 keeps requesting
    do_reset();
    wbase = 64'hBEEF_0000_0000_0000;
    set_req(1, 1'b0, 1'b1, 25'h200, 3'd4);
    req_writedata[DATA_W +: DATA_W] = wbase;
    #1;
    chk("wb_idle", 64'(amm_write), 64'h0);
    step();
    set_req(0, 1'b1, 1'b0, 25'h300, 3'd1);
    wpat = '{1, 0, 1, 0, 0, 1, 0};
    b    = 0;
    nacc = 0;
    for (int c = 0; c < 7; c++) begin
      amm_waitrequest = wpat[c][0];
      req_writedata[DATA_W +: DATA_W] = wbase + 64'(b);
      #1;
      chk("wb_write", 64'(amm_write), 64'h1);
      chk("wb_no_read", 64'(amm_read), 64'h0);
      chk("wb_addr", 64'(amm_address), 64'h200);
      chk("wb_burst", 64'(amm_burstcount), 64'h4);
      chk("wb_be", 64'(amm_byteenable), 64'hFF);
      chk("wb_wdata", amm_writedata, wbase + 64'(b));
      chk("wb_waitreq", 64'(req_waitrequest), (wpat[c] != 0) ? 64'h7 : 64'h5);
      if (amm_write && !amm_waitrequest) nacc++;
      if (wpat[c] == 0) b++;
      step();
    end
    req_write[1]    = 1'b0;
    amm_waitrequest = 1'b0;
    #1;
    chk("wb_beats", 64'(nacc), 64'h4);
    chk("wb_gap_write", 64'(amm_write), 64'h0);
    chk("wb_gap_read", 64'(amm_read), 64'h0);
    step();
    #1;
    chk("wb_next_read", 64'(amm_read), 64'h1);
    chk("wb_next_addr", 64'(amm_address), 64'h300);
    chk("wb_next_waitreq", 64'(req_waitrequest), 64'h6);
    step();
    req_read[0] = 1'b0;
`ifdef DDR_ARB_PERF_CNT_EN
    #1;
    chk("perf_grants", 64'(perf_grant_cnt), 64'h1_0000_0001);
    chk("perf_stalls", 64'(perf_stall_cnt), 64'h3);
`endif

    // Read routing: req2 burst 4 then req0 burst 2
    do_reset();
    set_req(2, 1'b1, 1'b0, 25'h400, 3'd4);
    #1;
    chk("rt_idle0", 64'(amm_read), 64'h0);
    step();
    #1;
    chk("rt_read2", 64'(amm_read), 64'h1);
    chk("rt_addr2", 64'(amm_address), 64'h400);
    chk("rt_burst2", 64'(amm_burstcount), 64'h4);
    chk("rt_waitreq2", 64'(req_waitrequest), 64'h3);
    step();
    set_req(2, 1'b0, 1'b0, 25'h400, 3'd4);
    set_req(0, 1'b1, 1'b0, 25'h500, 3'd2);
    #1;
    chk("rt_idle1", 64'(amm_read), 64'h0);
    step();
    #1;
    chk("rt_read0", 64'(amm_read), 64'h1);
    chk("rt_addr0", 64'(amm_address), 64'h500);
    chk("rt_burst0", 64'(amm_burstcount), 64'h2);
    step();
    set_req(0, 1'b0, 1'b0, 25'h500, 3'd2);
    vpat = '{1, 0, 1, 1, 0, 1, 0, 1, 1};
    b    = 0;
    for (int c = 0; c < 9; c++) begin
      amm_readdatavalid = vpat[c][0];
      amm_readdata      = 64'hD000_0000_0000_0000 + 64'(c);
      #1;
      chk("rt_rdv", 64'(req_readdatavalid),
          (vpat[c] == 0) ? 64'h0 : ((b < 4) ? 64'h4 : 64'h1));
      chk("rt_rdata", req_readdata, 64'hD000_0000_0000_0000 + 64'(c));
      if (vpat[c] != 0) b++;
      step();
    end
    amm_readdatavalid = 1'b0;
    #1;
    chk("rt_rdv_done", 64'(req_readdatavalid), 64'h0);

    // Tag FIFO full: 8 reads outstanding, 9th must wait for a pop
    do_reset();
    set_req(0, 1'b1, 1'b0, 25'h600, 3'd2);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("tf_idle", 64'(amm_read), 64'h0);
      step();
      #1;
      chk("tf_read", 64'(amm_read), 64'h1);
      chk("tf_burst", 64'(amm_burstcount), (k == 0) ? 64'h2 : 64'h1);
      step();
      if (k == 0) set_req(0, 1'b1, 1'b0, 25'h600, 3'd1);
    end
    #1;
    chk("tf_idle9", 64'(amm_read), 64'h0);
    step();
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("tf_stall_read", 64'(amm_read), 64'h0);
      chk("tf_stall_waitreq", 64'(req_waitrequest), 64'h7);
      step();
    end
    amm_readdatavalid = 1'b1;
    amm_readdata      = 64'h0000_0000_0000_00A1;
    #1;
    chk("tf_beat1_rdv", 64'(req_readdatavalid), 64'h1);
    chk("tf_beat1_read", 64'(amm_read), 64'h0);
    step();
    amm_readdata = 64'h0000_0000_0000_00A2;
    #1;
    chk("tf_beat2_rdv", 64'(req_readdatavalid), 64'h1);
    chk("tf_beat2_read", 64'(amm_read), 64'h0);
    step();
    amm_readdatavalid = 1'b0;
    #1;
    chk("tf_release_read", 64'(amm_read), 64'h1);
    chk("tf_release_waitreq", 64'(req_waitrequest), 64'h6);
    step();
    req_read[0] = 1'b0;

    // Reset during a write burst, with one read tag outstanding
    do_reset();
    set_req(2, 1'b1, 1'b0, 25'h080, 3'd1);
    step();
    #1;
    chk("mr_read2", 64'(amm_read), 64'h1);
    step();
    set_req(2, 1'b0, 1'b0, 25'h080, 3'd1);
    set_req(1, 1'b0, 1'b1, 25'h700, 3'd4);
    step();
    #1;
    chk("mr_beat0", 64'(amm_write), 64'h1);
    step();
    #1;
    chk("mr_beat1", 64'(amm_write), 64'h1);
    step();
    reset_reset = 1'b1;
    step();
    reset_reset  = 1'b0;
    req_write[1] = 1'b0;
    #1;
    chk("mr_write", 64'(amm_write), 64'h0);
    chk("mr_read", 64'(amm_read), 64'h0);
    chk("mr_waitreq", 64'(req_waitrequest), 64'h7);
    chk("mr_fifo_empty", 64'(dut.fifo_empty), 64'h1);
`ifdef DDR_ARB_PERF_CNT_EN
    chk("mr_perf_grants", 64'(perf_grant_cnt), 64'h0);
    chk("mr_perf_stalls", 64'(perf_stall_cnt), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
